// File: rtl/fifo_serial_tx_pkg.sv
// fifo_tx_pkg: shared types for fifo_serial_tx.
// Contents: the FSM state enum, the parity mode codes and frame_clocks(),
// which gives the length of one frame in clocks.
package fifo_tx_pkg;
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PAR, STOP} tx_state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  function automatic int frame_clocks(input int data_w, input int parity, input int stop_bits,
                                      input int clks_per_bit);
    return (1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
  endfunction
endpackage

// File: rtl/fifo_serial_tx_if.sv
// fifo_serial_tx_if: FIFO read port plus serial-side signals of fifo_serial_tx.
// Signals:
//   enable       - permits new frames (driven by the slave side)
//   fifo_empty   - FIFO empty flag
//   fifo_rd_data - FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   - one-cycle pop strobe
//   tx           - serial line, idle high
//   busy         - transmitter not idle
//   frame_done   - pulse on the last stop-bit clock
// The master modport is the transmitter. The slave modport is the FIFO/system side.
interface fifo_serial_tx_if #(parameter int DATA_W = 4);
  logic              enable;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_en;
  logic              tx;
  logic              busy;
  logic              frame_done;
  modport master (input enable, fifo_empty, fifo_rd_data, output fifo_rd_en, tx, busy, frame_done);
  modport slave  (output enable, fifo_empty, fifo_rd_data, input fifo_rd_en, tx, busy, frame_done);
endinterface

// File: rtl/fifo_serial_tx_baud_timer.sv
// baud_timer: loadable down-counter that produces one tick every CLKS_PER_BIT clocks.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   load_i     - restart the count; the first tick follows CLKS_PER_BIT clocks later
//   tick_o     - high on the final clock of each bit period
module baud_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic tick_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == '0;
  // The counter restarts on a load or on a tick, so it never wraps by underflow.
  assign cnt_d = (load_i || tick_o) ? RELOAD : cnt_q - 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops words from a sync FIFO and sends each as a UART-style frame.
// Frame format: start bit, LSB-first data, optional parity, then stop bit(s).
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - fifo_serial_tx_if.master, carrying:
//                enable, fifo_empty, fifo_rd_data (in)
//                fifo_rd_en, tx, busy, frame_done (out)
module fifo_serial_tx
  import fifo_tx_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input logic                clk,
  input logic                rst_n,
  fifo_serial_tx_if.master   bus
);
  localparam int BW = $clog2(DATA_W + 1);
  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              par_q, par_d;
  logic              tick, last_data, last_stop;
  // Every state change restarts the bit timer. Changes inside a frame already
  // land on a tick, so this only matters when a frame starts.
  baud_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (state_d != state_q),
    .tick_o (tick)
  );
  // bit_q counts data bits in DATA and then counts stop bits in STOP.
  assign last_data = bit_q == BW'(DATA_W - 1);
  assign last_stop = bit_q == BW'(STOP_BITS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
    end
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    par_d   = par_q;
    case (state_q)
      IDLE:  state_d = (bus.enable && !bus.fifo_empty) ? POP : IDLE;
      POP:   state_d = LOAD;
      LOAD: begin
        sh_d    = bus.fifo_rd_data;
        par_d   = ^bus.fifo_rd_data ^ (PARITY == PAR_ODD);
        bit_d   = '0;
        state_d = START;
      end
      START: state_d = tick ? DATA : START;
      DATA:
        if (tick) begin
          sh_d    = sh_q >> 1;
          bit_d   = last_data ? '0 : bit_q + 1'b1;
          state_d = !last_data ? DATA : (PARITY != PAR_NONE) ? PAR : STOP;
        end
      PAR:   state_d = tick ? STOP : PAR;
      STOP:
        if (tick) begin
          bit_d   = last_stop ? '0 : bit_q + 1'b1;
          state_d = last_stop ? IDLE : STOP;
        end
      default: state_d = IDLE;
    endcase
  end
  // Outputs decode directly from the state registers, so reset drives tx high at once.
  assign bus.fifo_rd_en = state_q == POP;
  assign bus.busy       = state_q != IDLE;
  assign bus.frame_done = (state_q == STOP) && tick && last_stop;
  assign bus.tx         = (state_q == START) ? 1'b0 :
                          (state_q == DATA)  ? sh_q[0] :
                          (state_q == PAR)   ? par_q : 1'b1;
endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx: directed tests of fifo_serial_tx.
// Three instances share one clock and reset: no parity, even parity and odd parity.
// All use DATA_W=4 and CLKS_PER_BIT=4.
module tb_fifo_serial_tx;
  localparam int C = 4;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  int rd0 = 0;
  logic [3:0] q0[$], q1[$], q2[$];
  always #5 clk = ~clk;
  fifo_serial_tx_if #(.DATA_W(4)) b0 ();
  fifo_serial_tx_if #(.DATA_W(4)) b1 ();
  fifo_serial_tx_if #(.DATA_W(4)) b2 ();
  fifo_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  fifo_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  fifo_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  // FIFO model: a pop presents the word on the next cycle.
  always @(posedge clk) begin
    if (b0.fifo_rd_en && q0.size() > 0) b0.fifo_rd_data <= q0.pop_front();
    if (b1.fifo_rd_en && q1.size() > 0) b1.fifo_rd_data <= q1.pop_front();
    if (b2.fifo_rd_en && q2.size() > 0) b2.fifo_rd_data <= q2.pop_front();
    if (b0.fifo_rd_en) rd0 <= rd0 + 1;
  end
  always @(negedge clk) begin
    b0.fifo_empty = q0.size() == 0;
    b1.fifo_empty = q1.size() == 0;
    b2.fifo_empty = q2.size() == 0;
  end
  // Expected line level k clocks after the start bit begins.
  function automatic logic exp_tx(input logic [3:0] d, input int p, input int k);
    int s;
    s = k / C;
    if (s == 0) return 1'b0;
    if (s <= 4) return d[s-1];
    if (p != 0 && s == 5) return (p == 1) ? ^d : ~^d;
    return 1'b1;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_pop(input int w, output bit f);
    f = 1'b0;
    for (int i = 0; i < 10 && !f; i++) begin
      step();
      f = (w == 0) ? b0.fifo_rd_en : (w == 1) ? b1.fifo_rd_en : b2.fifo_rd_en;
    end
  endtask
  task automatic test_reset();
    int hits, lvl;
    rst_n = 1'b0;
    b0.enable = 1'b1;
    b1.enable = 1'b1;
    b2.enable = 1'b1;
    step();
    step();
    total++; if (b0.tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", b0.tx); end
    total++; if (b0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", b0.busy); end
    total++; if (b0.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", b0.fifo_rd_en); end
    total++; if (b0.frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", b0.frame_done); end
    @(negedge clk) rst_n = 1'b1;
    hits = 0;
    lvl = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (b0.fifo_rd_en !== 1'b0) hits++;
      if (b0.tx !== 1'b1 || b0.busy !== 1'b0) lvl++;
    end
    total++; if (hits != 0) begin bad++; $display("FAIL idle_no_pop got=%0d exp=0", hits); end
    total++; if (lvl != 0) begin bad++; $display("FAIL idle_levels got=%0d exp=0", lvl); end
  endtask
  task automatic test_single();
    bit f;
    logic [3:0] d;
    d = 4'b1010;
    q0.push_back(d);
    wait_pop(0, f);
    total++; if (!f) begin bad++; $display("FAIL single_pop got=0 exp=1"); end
    step();
    total++; if (b0.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL single_pop_width got=%b exp=0", b0.fifo_rd_en); end
    total++; if (b0.tx !== 1'b1) begin bad++; $display("FAIL single_load_tx got=%b exp=1", b0.tx); end
    step();
    for (int k = 0; k < 24; k++) begin
      if (k > 0) step();
      total++; if (b0.tx !== exp_tx(d, 0, k)) begin bad++; $display("FAIL single_tx k=%0d got=%b exp=%b", k, b0.tx, exp_tx(d, 0, k)); end
      total++; if (b0.frame_done !== (k == 23)) begin bad++; $display("FAIL single_done k=%0d got=%b exp=%b", k, b0.frame_done, k == 23); end
      total++; if (b0.busy !== 1'b1) begin bad++; $display("FAIL single_busy k=%0d got=%b exp=1", k, b0.busy); end
    end
    step();
    total++; if (b0.busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", b0.busy); end
    total++; if (b0.tx !== 1'b1) begin bad++; $display("FAIL single_tx_end got=%b exp=1", b0.tx); end
  endtask
  task automatic test_back_to_back();
    bit f;
    int r;
    logic [3:0] d1, d2;
    d1 = 4'b1010;
    d2 = 4'b1100;
    r = rd0;
    q0.push_back(d1);
    q0.push_back(d2);
    wait_pop(0, f);
    total++; if (!f) begin bad++; $display("FAIL b2b_pop got=0 exp=1"); end
    step();
    step();
    for (int k = 0; k < 24; k++) begin
      if (k > 0) step();
      total++; if (b0.tx !== exp_tx(d1, 0, k)) begin bad++; $display("FAIL b2b_tx1 k=%0d got=%b exp=%b", k, b0.tx, exp_tx(d1, 0, k)); end
    end
    for (int g = 0; g < 3; g++) begin
      step();
      total++; if (b0.tx !== 1'b1) begin bad++; $display("FAIL b2b_gap g=%0d got=%b exp=1", g, b0.tx); end
      total++; if (b0.fifo_rd_en !== (g == 1)) begin bad++; $display("FAIL b2b_gap_pop g=%0d got=%b exp=%b", g, b0.fifo_rd_en, g == 1); end
    end
    step();
    for (int k = 0; k < 24; k++) begin
      if (k > 0) step();
      total++; if (b0.tx !== exp_tx(d2, 0, k)) begin bad++; $display("FAIL b2b_tx2 k=%0d got=%b exp=%b", k, b0.tx, exp_tx(d2, 0, k)); end
    end
    for (int i = 0; i < 5; i++) step();
    total++; if (rd0 - r != 2) begin bad++; $display("FAIL b2b_pops got=%0d exp=2", rd0 - r); end
  endtask
  task automatic test_parity();
    bit f;
    logic [3:0] d;
    d = 4'b0111;
    q1.push_back(d);
    q2.push_back(d);
    wait_pop(1, f);
    total++; if (!f) begin bad++; $display("FAIL par_pop got=0 exp=1"); end
    total++; if (b2.fifo_rd_en !== 1'b1) begin bad++; $display("FAIL par_pop_odd got=%b exp=1", b2.fifo_rd_en); end
    step();
    step();
    for (int k = 0; k < 28; k++) begin
      if (k > 0) step();
      total++; if (b1.tx !== exp_tx(d, 1, k)) begin bad++; $display("FAIL par_even_tx k=%0d got=%b exp=%b", k, b1.tx, exp_tx(d, 1, k)); end
      total++; if (b2.tx !== exp_tx(d, 2, k)) begin bad++; $display("FAIL par_odd_tx k=%0d got=%b exp=%b", k, b2.tx, exp_tx(d, 2, k)); end
      total++; if (b1.frame_done !== (k == 27)) begin bad++; $display("FAIL par_done k=%0d got=%b exp=%b", k, b1.frame_done, k == 27); end
      if (k == 20) begin
        total++; if (b1.tx !== 1'b1) begin bad++; $display("FAIL par_even_bit got=%b exp=1", b1.tx); end
        total++; if (b2.tx !== 1'b0) begin bad++; $display("FAIL par_odd_bit got=%b exp=0", b2.tx); end
      end
    end
    step();
    total++; if (b1.busy !== 1'b0) begin bad++; $display("FAIL par_even_len got=%b exp=0", b1.busy); end
    total++; if (b2.busy !== 1'b0) begin bad++; $display("FAIL par_odd_len got=%b exp=0", b2.busy); end
  endtask
  task automatic test_enable();
    bit f;
    int r, hits, lvl;
    logic [3:0] d;
    d = 4'b1001;
    r = rd0;
    q0.push_back(d);
    q0.push_back(4'b0011);
    wait_pop(0, f);
    total++; if (!f) begin bad++; $display("FAIL en_pop got=0 exp=1"); end
    step();
    step();
    for (int k = 0; k < 24; k++) begin
      if (k > 0) step();
      if (k == 8) b0.enable = 1'b0;
      total++; if (b0.tx !== exp_tx(d, 0, k)) begin bad++; $display("FAIL en_tx k=%0d got=%b exp=%b", k, b0.tx, exp_tx(d, 0, k)); end
    end
    hits = 0;
    lvl = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (b0.fifo_rd_en !== 1'b0) hits++;
      if (b0.tx !== 1'b1) lvl++;
    end
    total++; if (hits != 0) begin bad++; $display("FAIL en_no_pop got=%0d exp=0", hits); end
    total++; if (lvl != 0) begin bad++; $display("FAIL en_idle_tx got=%0d exp=0", lvl); end
    total++; if (rd0 - r != 1) begin bad++; $display("FAIL en_pops got=%0d exp=1", rd0 - r); end
    b0.enable = 1'b1;
    wait_pop(0, f);
    total++; if (!f) begin bad++; $display("FAIL en_resume_pop got=0 exp=1"); end
    step();
    step();
    total++; if (b0.tx !== 1'b0) begin bad++; $display("FAIL en_resume_start got=%b exp=0", b0.tx); end
    f = 1'b0;
    for (int i = 0; i < 40 && !f; i++) begin
      step();
      f = b0.frame_done;
    end
    total++; if (!f) begin bad++; $display("FAIL en_resume_done got=0 exp=1"); end
    step();
  endtask
  task automatic test_reset_mid();
    bit f;
    logic [3:0] d;
    d = 4'b0110;
    q0.push_back(4'b1010);
    wait_pop(0, f);
    total++; if (!f) begin bad++; $display("FAIL rmid_pop got=0 exp=1"); end
    step();
    step();
    step();
    total++; if (b0.tx !== 1'b0) begin bad++; $display("FAIL rmid_start got=%b exp=0", b0.tx); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (b0.tx !== 1'b1) begin bad++; $display("FAIL rmid_tx got=%b exp=1", b0.tx); end
    total++; if (b0.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", b0.busy); end
    total++; if (q0.size() != 0) begin bad++; $display("FAIL rmid_discard got=%0d exp=0", q0.size()); end
    q0.push_back(d);
    @(negedge clk) rst_n = 1'b1;
    wait_pop(0, f);
    total++; if (!f) begin bad++; $display("FAIL rmid_repop got=0 exp=1"); end
    step();
    step();
    for (int k = 0; k < 24; k++) begin
      if (k > 0) step();
      total++; if (b0.tx !== exp_tx(d, 0, k)) begin bad++; $display("FAIL rmid_tx k=%0d got=%b exp=%b", k, b0.tx, exp_tx(d, 0, k)); end
      total++; if (b0.frame_done !== (k == 23)) begin bad++; $display("FAIL rmid_done k=%0d got=%b exp=%b", k, b0.frame_done, k == 23); end
    end
    step();
    total++; if (b0.busy !== 1'b0) begin bad++; $display("FAIL rmid_end got=%b exp=0", b0.busy); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
